// File: rtl/pad_cfg_ctrl.sv
// Padring control owner: per-pad shadow registers on a simple req/ready bus,
// and a commit FSM that copies shadow to the live pad controls one side at a time.
module pad_cfg_ctrl #(
   parameter int NPADS         = 9,
   parameter int TCW           = 16,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 we,
   input  logic [5:0]           addr,
   input  logic [31:0]          wdata,
   output logic                 ready,
   output logic [31:0]          rdata,
   output logic                 err,
   output logic                 busy,
   output logic                 done,
   output logic [NPADS-1:0]     no_ie,
   output logic [NPADS-1:0]     ea_ie,
   output logic [NPADS-1:0]     so_ie,
   output logic [NPADS-1:0]     we_ie,
   output logic [NPADS-1:0]     no_oen,
   output logic [NPADS-1:0]     ea_oen,
   output logic [NPADS-1:0]     so_oen,
   output logic [NPADS-1:0]     we_oen,
   output logic [NPADS*TCW-1:0] no_tech_cfg,
   output logic [NPADS*TCW-1:0] ea_tech_cfg,
   output logic [NPADS*TCW-1:0] so_tech_cfg,
   output logic [NPADS*TCW-1:0] we_tech_cfg
);

   localparam int NSIDE     = 4;
   localparam int NPAD_TOT  = NSIDE * NPADS;
   localparam int CTRL_ADDR = 63;
   localparam int CW        = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   // bus side
   logic        r_ready;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_commit_pend;
   logic        r_done;
   logic        r_done_sticky;

   logic        w_xact;
   logic        w_pad_hit;
   logic        w_ctrl_hit;
   logic        w_pad_wr;
   logic        w_ctrl_rd;
   logic        w_commit;
   logic [31:0] w_pad_rdata;
   logic        w_unused;

   // commit FSM
   state_t          r_state, w_state_nxt;
   logic [1:0]      r_side, w_side_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            w_apply;
   logic            w_done_evt;

   // shadow and live pad state, indexed by side (0=no, 1=ea, 2=so, 3=we)
   logic [NPADS-1:0]     r_sh_ie    [NSIDE];
   logic [NPADS-1:0]     r_sh_oen   [NSIDE];
   logic [NPADS*TCW-1:0] r_sh_tc    [NSIDE];
   logic [NPADS-1:0]     r_live_ie  [NSIDE];
   logic [NPADS-1:0]     r_live_oen [NSIDE];
   logic [NPADS*TCW-1:0] r_live_tc  [NSIDE];

   // A transaction is accepted only when ready is low, so ready never repeats.
   assign w_xact     = req & ~r_ready;
   assign w_pad_hit  = (addr < 6'(NPAD_TOT));
   assign w_ctrl_hit = (addr == 6'(CTRL_ADDR));
   assign w_pad_wr   = w_xact & we & w_pad_hit;
   assign w_ctrl_rd  = w_xact & ~we & w_ctrl_hit;
   assign w_commit   = w_xact & we & w_ctrl_hit & wdata[0];
   assign w_unused   = ^wdata;

   // NOTE: every variable gets a default before the loop, so no latch can be inferred.
   always_comb begin
      w_pad_rdata = '0;
      for (int s = 0; s < NSIDE; s++) begin
         for (int i = 0; i < NPADS; i++) begin
            if (addr == 6'(s * NPADS + i)) begin
               w_pad_rdata[0]          = r_sh_ie[s][i];
               w_pad_rdata[1]          = r_sh_oen[s][i];
               w_pad_rdata[16 +: TCW]  = r_sh_tc[s][i*TCW +: TCW];
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready       <= 1'b0;
         r_rdata       <= '0;
         r_err         <= 1'b0;
         r_commit_pend <= 1'b0;
      end else begin
         r_ready       <= w_xact;
         r_commit_pend <= w_commit;
         r_err         <= w_xact & ~w_pad_hit & ~w_ctrl_hit;
         if (w_xact & ~we & w_pad_hit)
            r_rdata <= w_pad_rdata;
         else if (w_ctrl_rd)
            r_rdata <= {30'b0, r_done_sticky, busy};
         else
            r_rdata <= '0;
      end
   end

   // A done event wins over a simultaneous CTRL read-clear.
   always_ff @(posedge clk) begin
      if (rst)
         r_done_sticky <= 1'b0;
      else if (w_done_evt)
         r_done_sticky <= 1'b1;
      else if (w_ctrl_rd)
         r_done_sticky <= 1'b0;
   end

   // NOTE: the shadow arrays are plain flops that must come up at pad-safe values, so they are reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NSIDE; s++) begin
            r_sh_ie[s]    <= '0;
            r_sh_oen[s]   <= '1;
            r_sh_tc[s]    <= '0;
            r_live_ie[s]  <= '0;
            r_live_oen[s] <= '1;
            r_live_tc[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < NSIDE; s++) begin
            for (int i = 0; i < NPADS; i++) begin
               if (w_pad_wr && addr == 6'(s * NPADS + i)) begin
                  r_sh_ie[s][i]               <= wdata[0];
                  r_sh_oen[s][i]              <= wdata[1];
                  r_sh_tc[s][i*TCW +: TCW]    <= wdata[16 +: TCW];
               end
            end
            // Live takes the shadow as it stood before this edge's bus write.
            if (w_apply && r_side == 2'(s)) begin
               r_live_ie[s]  <= r_sh_ie[s];
               r_live_oen[s] <= r_sh_oen[s];
               r_live_tc[s]  <= r_sh_tc[s];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_side  <= 2'd0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_side  <= w_side_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_evt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_side_nxt  = r_side;
      w_cnt_nxt   = r_cnt;
      w_apply     = 1'b0;
      w_done_evt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Commits arriving while a sequence runs never reach here and are dropped.
            if (r_commit_pend) begin
               w_state_nxt = ST_APPLY;
               w_side_nxt  = 2'd0;
            end
         end
         ST_APPLY: begin
            w_apply = 1'b1;
            if (r_side == 2'd3) begin
               w_state_nxt = ST_IDLE;
               w_side_nxt  = 2'd0;
               w_done_evt  = 1'b1;
            end else if (SETTLE_CYCLES == 0) begin
               w_side_nxt  = r_side + 2'd1;
            end else begin
               w_state_nxt = ST_SETTLE;
               w_cnt_nxt   = SETTLE_INIT;
            end
         end
         ST_SETTLE: begin
            if (r_cnt <= CW'(1)) begin
               w_state_nxt = ST_APPLY;
               w_side_nxt  = r_side + 2'd1;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign ready       = r_ready;
   assign rdata       = r_rdata;
   assign err         = r_err;
   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;

   assign no_ie       = r_live_ie[0];
   assign ea_ie       = r_live_ie[1];
   assign so_ie       = r_live_ie[2];
   assign we_ie       = r_live_ie[3];
   assign no_oen      = r_live_oen[0];
   assign ea_oen      = r_live_oen[1];
   assign so_oen      = r_live_oen[2];
   assign we_oen      = r_live_oen[3];
   assign no_tech_cfg = r_live_tc[0];
   assign ea_tech_cfg = r_live_tc[1];
   assign so_tech_cfg = r_live_tc[2];
   assign we_tech_cfg = r_live_tc[3];

endmodule
